keypad_scan: RTL and testbench



---
 rtl/keypad_scan.sv | 151 +++++++++++++++
 tb/tb_keypad_scan.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one column at a time, synchronizes and
// debounces the rows, and presents the single stable key as a one-hot code.
module keypad_scan #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] conv8,
  output logic       key_valid,
  output logic       key_release
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      sync1_q, sync1_d;
  logic [3:0]      row_s_q, row_s_d;
  logic [3:0]      col_q, col_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [CW-1:0]   match_q, match_d;
  logic [CW-1:0]   rel_q, rel_d;
  logic [3:0]      cand_row_q, cand_row_d;
  logic [3:0]      cand_col_q, cand_col_d;
  logic [7:0]      conv8_q, conv8_d;
  logic            valid_q, valid_d;
  logic            release_q, release_d;

  logic            row_one_hot;
  logic [3:0]      col_next;

  assign row_one_hot = (row_s_q != 4'd0) && ((row_s_q & (row_s_q - 4'd1)) == 4'd0);
  assign col_next    = {col_q[2:0], col_q[3]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_SCAN;
      sync1_q    <= 4'd0;
      row_s_q    <= 4'd0;
      col_q      <= 4'b0001;
      dwell_q    <= '0;
      match_q    <= '0;
      rel_q      <= '0;
      cand_row_q <= 4'd0;
      cand_col_q <= 4'd0;
      conv8_q    <= 8'h00;
      valid_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      row_s_q    <= row_s_d;
      col_q      <= col_d;
      dwell_q    <= dwell_d;
      match_q    <= match_d;
      rel_q      <= rel_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
      conv8_q    <= conv8_d;
      valid_q    <= valid_d;
      release_q  <= release_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sync1_d    = row_in;
    row_s_d    = sync1_q;
    col_d      = col_q;
    dwell_d    = dwell_q;
    match_d    = match_q;
    rel_d      = rel_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    conv8_d    = conv8_q;
    valid_d    = 1'b0;
    release_d  = 1'b0;
    case (state_q)
      ST_SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (row_one_hot) begin
            cand_row_d = row_s_q;
            cand_col_d = col_q;
            match_d    = CW'(1);
            state_d    = ST_DEBOUNCE;
          end else begin
            col_d = col_next;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (row_s_q == cand_row_q) begin
          if (match_q + CW'(1) == CNT_DONE) begin
            conv8_d = {cand_col_q, cand_row_q};
            valid_d = 1'b1;
            match_d = '0;
            rel_d   = '0;
            state_d = ST_HELD;
          end else begin
            match_d = match_q + CW'(1);
          end
        end else begin
          // Abandon this candidate and move on rather than re-dwelling here.
          match_d = '0;
          col_d   = col_next;
          dwell_d = '0;
          state_d = ST_SCAN;
        end
      end
      ST_HELD: begin
        if (row_s_q != cand_row_q) begin
          if (rel_q + CW'(1) == CNT_DONE) begin
            conv8_d   = 8'h00;
            release_d = 1'b1;
            col_d     = 4'b0001;
            dwell_d   = '0;
            rel_d     = '0;
            state_d   = ST_SCAN;
          end else begin
            rel_d = rel_q + CW'(1);
          end
        end else begin
          rel_d = '0;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_comb begin
    col_out     = col_q;
    conv8       = conv8_q;
    key_valid   = valid_q;
    key_release = release_q;
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad model on the row lines, expected-event
// scoreboard popped by a monitor on key_valid / key_release pulses.
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 4;
  localparam int W = 41;

  logic       clock;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] conv8;
  logic       key_valid;
  logic       key_release;

  logic [3:0][3:0] keys;
  logic [W-1:0]    exp_q[$];
  int              tests;
  int              fails;
  int              cyc;
  int              cyc0;
  logic [7:0]      prev_conv8;

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clock      (clock),
    .reset      (reset),
    .row_in     (row_in),
    .col_out    (col_out),
    .conv8      (conv8),
    .key_valid  (key_valid),
    .key_release(key_release)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc = cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // keypad model: a pressed key (c,r) connects column c to row r
  always_comb begin
    row_in = 4'd0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c][r] && col_out[c]) row_in[r] = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] code(input int c, input int r);
    logic [3:0] cm;
    logic [3:0] rm;
    cm = 4'b0001 << c;
    rm = 4'b0001 << r;
    return {cm, rm};
  endfunction

  // monitor / scoreboard
  always @(negedge clock) begin
    logic [W-1:0] e;
    if (!reset) begin
      check("pulse_excl", 32'(key_valid & key_release), 0);
      if (key_valid || key_release) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 32'({key_valid, key_release}), 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", 32'(key_valid), 32'(e[40]));
          check("pulse_conv8", 32'(conv8), 32'(e[39:32]));
          if (key_release && e[31:0] != 32'd0)
            check("release_latency", cyc, int'(e[31:0]));
        end
      end else begin
        check("conv8_stable", 32'(conv8), 32'(prev_conv8));
      end
    end
    prev_conv8 = conv8;
  end

  // driver tasks
  task automatic do_reset_on();
    @(negedge clock);
    #2 reset = 1'b1;
  endtask

  task automatic do_reset_off();
    @(negedge clock);
    #2 reset = 1'b0;
    cyc0 = cyc;
  endtask

  task automatic press(input int c, input int r);
    @(negedge clock);
    keys[c][r] = 1'b1;
    exp_q.push_back({1'b1, code(c, r), 32'd0});
  endtask

  task automatic release_all();
    @(negedge clock);
    keys = '0;
    exp_q.push_back({1'b0, 8'h00, 32'(cyc + 2 + DEBOUNCE)});
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic hold(input int n, input int c, input logic [7:0] exp_code);
    logic [3:0] cm;
    cm = 4'b0001 << c;
    repeat (n) begin
      @(negedge clock);
      #1;
      check("held_col", 32'(col_out), 32'(cm));
      check("held_conv8", 32'(conv8), 32'(exp_code));
    end
  endtask

  task automatic press_release(input int c, input int r, input int n);
    press(c, r);
    wait_drain(64);
    check("accept_conv8", 32'(conv8), 32'(code(c, r)));
    hold(n, c, code(c, r));
    release_all();
    wait_drain(64);
    check("release_conv8", 32'(conv8), 0);
    check("release_col", 32'(col_out), 1);
  endtask

  initial begin
    logic [3:0] seen;
    int c, r, n, gap;
    tests = 0;
    fails = 0;
    cyc = 0;
    keys = '0;
    reset = 1'b1;
    prev_conv8 = 8'h00;
    #1;
    check("reset_col", 32'(col_out), 1);
    check("reset_conv8", 32'(conv8), 0);
    check("reset_pulses", 32'({key_valid, key_release}), 0);

    // 1: idle scan
    do_reset_off();
    for (int k = 1; k <= 64; k++) begin
      @(negedge clock);
      #1;
      check("idle_col", 32'(col_out), 1 << (((cyc - cyc0) / SCAN_DIV) % 4));
      check("idle_conv8", 32'(conv8), 0);
    end

    // 2: single press (col 2, row 1)
    press_release(2, 1, 100);

    // 3: dropout during debounce, key held through reset
    do_reset_on();
    keys[0][0] = 1'b1;
    do_reset_off();
    repeat (4) @(negedge clock);
    keys[0][0] = 1'b0;
    @(negedge clock);
    keys[0][0] = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check("retry_col", 32'(col_out), 2);
    exp_q.push_back({1'b1, code(0, 0), 32'd0});
    wait_drain(64);
    check("retry_conv8", 32'(conv8), 32'(8'b0001_0001));
    release_all();
    wait_drain(64);

    // 4: two keys in one column never accepted
    @(negedge clock);
    keys[3][0] = 1'b1;
    keys[3][3] = 1'b1;
    seen = 4'd0;
    repeat (80) begin
      @(negedge clock);
      #1;
      seen = seen | col_out;
      check("multi_conv8", 32'(conv8), 0);
    end
    check("multi_rotate", 32'(seen), 32'hF);
    keys = '0;
    repeat (8) @(negedge clock);

    // 5: short glitch in HELD is ignored
    press(1, 3);
    wait_drain(64);
    check("glitch_conv8_pre", 32'(conv8), 32'(8'b0010_1000));
    hold(10, 1, code(1, 3));
    keys[1][3] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    keys[1][3] = 1'b1;
    hold(20, 1, code(1, 3));
    release_all();
    wait_drain(64);

    // 6: reset mid-HELD, key re-accepted afterwards
    press(2, 2);
    wait_drain(64);
    hold(10, 2, code(2, 2));
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async_conv8", 32'(conv8), 0);
    check("async_col", 32'(col_out), 1);
    check("async_release", 32'(key_release), 0);
    exp_q.push_back({1'b1, code(2, 2), 32'd0});
    do_reset_off();
    wait_drain(64);
    hold(5, 2, code(2, 2));
    release_all();
    wait_drain(64);

    // random single presses
    for (int i = 0; i < 12; i++) begin
      c = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      n = $urandom_range(5, 40);
      gap = $urandom_range(0, 20);
      press_release(c, r, n);
      repeat (gap) @(negedge clock);
    end

    repeat (10) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
